// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scan tick default, emulator state encoding and
// the key-number to row/column index split used by both scanner and emulator.
package keypad_pkg;

  localparam int TICK_MAX_DEFAULT = 50;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Key k sits at row k[3:2], column k[1:0].
  localparam int ROW_IDX_MSB = 3;
  localparam int ROW_IDX_LSB = 2;
  localparam int COL_IDX_MSB = 1;
  localparam int COL_IDX_LSB = 0;

  function automatic logic [1:0] key_row(input logic [3:0] k);
    return k[ROW_IDX_MSB:ROW_IDX_LSB];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] k);
    return k[COL_IDX_MSB:COL_IDX_LSB];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small first-word-fall-through queue of 4-bit key requests.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_M,
  input  logic       reset,
  input  logic       push_i,
  input  logic [3:0] data_i,
  input  logic       pop_i,
  output logic [3:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_M) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_M or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates key presses on a scanned 4x4 matrix: queued key numbers are held
// pressed for HOLD_TICKS scan ticks, followed by GAP_TICKS of release.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int TICK_MAX   = TICK_MAX_DEFAULT,
  parameter int HOLD_TICKS = 40,
  parameter int GAP_TICKS  = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_M,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       key_done
);

  localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int NW = $clog2(((HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS) + 1);

  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_head;
  logic          pop;
  logic          tick;
  logic [TW-1:0] tick_cnt_q;

  state_e        state_q, state_d;
  logic [3:0]    key_q, key_d;
  logic [NW-1:0] ticks_q, ticks_d;
  logic [3:0]    row_q, row_d;
  logic          done_q, done_d;

  assign key_ready = ~fifo_full;
  assign busy      = (state_q != IDLE) | ~fifo_empty;
  assign row       = row_q;
  assign key_done  = done_q;
  assign tick      = (tick_cnt_q == TW'(TICK_MAX - 1));

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_M   (clk_M),
    .reset   (reset),
    .push_i  (key_valid & key_ready),
    .data_i  (key_code),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_M or posedge reset) begin
    if (reset)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ticks_d = ticks_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          key_d   = fifo_head;
          ticks_d = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (tick) begin
          if (ticks_q == NW'(HOLD_TICKS - 1)) begin
            ticks_d = '0;
            state_d = GAP;
          end else begin
            ticks_d = ticks_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (ticks_q == NW'(GAP_TICKS - 1)) begin
            ticks_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ticks_d = ticks_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Row is derived from the upcoming state so it is released on the very
    // edge that leaves PRESS and still tracks col with one cycle of latency.
    row_d = 4'b1111;
    if (state_d == PRESS && !col[key_col(key_d)]) row_d[key_row(key_d)] = 1'b0;
  end

  always_ff @(posedge clk_M or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      ticks_q <= '0;
      row_q   <= 4'b1111;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ticks_q <= ticks_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with a behavioural column scanner whose
// decoded keys are scoreboarded against the accepted request order.
module tb_keypad_emulator;

  localparam int TM = 50;

  logic       clk_M = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       key_done;

  logic       scan_en = 1'b0;
  logic [3:0] man_col = 4'b0000;
  logic [3:0] scan_col = 4'b0000;
  logic [3:0] col_s = 4'b0000;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dbl_done = 0;
  int done_cyc[$];
  int exp_q[$];
  int rep_q[$];

  bit mon6 = 0;
  int viol6 = 0;
  int low6 = 0;
  bit mon_quiet = 0;
  int quiet_viol = 0;

  int sc_cnt = 0;
  int sc_ph = 0;
  bit sc_hit = 0;
  bit sc_pressed = 0;
  bit prev_done = 0;

  assign col = scan_en ? scan_col : man_col;

  always #5 clk_M = ~clk_M;

  keypad_emulator dut (
    .clk_M     (clk_M),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .key_done  (key_done)
  );

  always @(posedge clk_M) begin
    cyc   <= cyc + 1;
    col_s <= col;
  end

  function automatic int decode_key(input logic [3:0] r, input int c);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < 4; i++) if (r[i] === 1'b0) begin idx = i; n++; end
    return (n == 1) ? (idx * 4 + c) : 255;
  endfunction

  // Scanner model: detect phase (0000) then one column low per tick period.
  initial begin
    forever begin
      @(negedge clk_M);
      if (sc_cnt == TM - 1) begin
        if (scan_en && sc_ph != 0) begin
          if (row !== 4'b1111) begin
            sc_hit = 1;
            if (!sc_pressed) begin
              sc_pressed = 1;
              rep_q.push_back(decode_key(row, sc_ph - 1));
            end
          end
          if (sc_ph == 4) begin
            if (!sc_hit) sc_pressed = 0;
            sc_hit = 0;
          end
        end
        sc_cnt = 0;
        sc_ph  = (sc_ph == 4) ? 0 : sc_ph + 1;
        case (sc_ph)
          1:       scan_col = 4'b1110;
          2:       scan_col = 4'b1101;
          3:       scan_col = 4'b1011;
          4:       scan_col = 4'b0111;
          default: scan_col = 4'b0000;
        endcase
      end else begin
        sc_cnt++;
      end
    end
  end

  // Output monitors sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_M);
      if (key_done === 1'b1) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        if (prev_done) dbl_done++;
      end
      prev_done = (key_done === 1'b1);
      if (mon6 && row !== 4'b1111) begin
        if (row === 4'b1101 && (col_s === 4'b1011 || col_s === 4'b0000)) low6++;
        else viol6++;
      end
      if (mon_quiet && row !== 4'b1111) quiet_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_key(input logic [3:0] k, input bit track, input int budget, output int acc);
    int n = 0;
    bit ok = 0;
    acc = -1;
    @(negedge clk_M);
    key_code  = k;
    key_valid = 1'b1;
    while (!ok && n < budget) begin
      if (key_ready === 1'b1) begin
        @(posedge clk_M);
        #1;
        ok  = 1;
        acc = cyc;
      end else begin
        @(negedge clk_M);
        n++;
      end
    end
    key_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
    if (ok && track) exp_q.push_back(int'(k));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk_M);
      n++;
    end
    check("key_done_wait", 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int acc6, acc12, acc, lat, dc, got, want;

    // Reset state with the scanner in detect phase
    man_col = 4'b0000;
    repeat (3) @(negedge clk_M);
    check("rst_row", 32'(row), 32'hF);
    check("rst_ready", 32'(key_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(key_done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_M);

    // Single key 6 under the scanner model, then a burst queued during its gap
    scan_en = 1'b1;
    mon6 = 1;
    push_key(4'd6, 1, 10, acc6);
    repeat (42 * TM) @(negedge clk_M);
    mon6 = 0;
    check("k6_busy_in_gap", 32'(busy), 32'd1);
    check("k6_no_done_yet", 32'(done_cnt), 32'd0);
    push_key(4'd0, 1, 10, acc);
    push_key(4'd15, 1, 10, acc);
    push_key(4'd9, 1, 10, acc);
    push_key(4'd3, 1, 10, acc);
    @(negedge clk_M);
    check("ready_low_when_full", 32'(key_ready), 32'd0);
    check("busy_when_full", 32'(busy), 32'd1);
    push_key(4'd12, 1, 4000, acc12);
    check("fifth_waited_for_pop", 32'(done_cnt == 1 && acc12 > done_cyc[0]), 32'd1);
    lat = done_cyc[0] - (acc6 + 1);
    check("k6_done_latency", 32'(lat >= 79 * TM + 1 && lat <= 80 * TM), 32'd1);
    check("k6_row_only_on_col", 32'(viol6), 32'd0);
    check("k6_row_seen_low", 32'(low6 > 0), 32'd1);
    wait_done(6, 6 * 82 * TM);
    repeat (2 * TM) @(negedge clk_M);
    check("done_pulse_count", 32'(done_cnt), 32'd6);
    check("done_single_cycle", 32'(dbl_done), 32'd0);
    check("busy_after_drain", 32'(busy), 32'd0);
    check("report_count", 32'(rep_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = (rep_q.size() > 0) ? rep_q.pop_front() : -1;
      check("scanner_key_order", 32'(got), 32'(want));
    end
    rep_q.delete();

    // Reset 10 ticks into the press of key 2 with two more queued
    scan_en = 1'b0;
    man_col = 4'b0000;
    push_key(4'd2, 0, 10, acc);
    push_key(4'd5, 0, 10, acc);
    push_key(4'd7, 0, 10, acc);
    repeat (10 * TM) @(negedge clk_M);
    check("k2_row_pressed", 32'(row), 32'b1110);
    dc = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_row", 32'(row), 32'hF);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(key_ready), 32'd1);
    check("rst_mid_done", 32'(key_done), 32'd0);
    repeat (3) @(negedge clk_M);
    reset = 1'b0;
    mon_quiet = 1;
    repeat (3000) @(negedge clk_M);
    mon_quiet = 0;
    check("rst_nothing_emulated", 32'(quiet_viol), 32'd0);
    check("rst_no_done", 32'(done_cnt), 32'(dc));
    check("rst_idle_busy", 32'(busy), 32'd0);

    // Key 3 lives in column 3: other columns must not pull its row
    man_col = 4'b1110;
    push_key(4'd3, 0, 10, acc);
    repeat (5) @(negedge clk_M);
    check("k3_col1110_row", 32'(row), 32'hF);
    check("k3_busy", 32'(busy), 32'd1);
    man_col = 4'b0111;
    #1;
    check("k3_row_before_edge", 32'(row), 32'hF);
    @(negedge clk_M);
    check("k3_col0111_row", 32'(row), 32'b1110);
    man_col = 4'b1111;
    @(negedge clk_M);
    check("k3_release_row", 32'(row), 32'hF);
    wait_done(dc + 1, 82 * TM);
    @(negedge clk_M);
    check("k3_done_count", 32'(done_cnt), 32'(dc + 1));
    check("k3_final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
